// File: rtl/rw_request_scheduler.sv
// Read/write request scheduler: two request FIFOs feeding the per-(channel, rank) FSM array, one issue per cycle.
// Reads have priority; a write backlog, an idle read queue or write starvation switches to write-drain mode.

module rw_req_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is presented until count_q says the slot is live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
endmodule

module rw_request_scheduler #(
  parameter int AXI_ADDRWIDTH = 32,
  parameter int AXI_IDWIDTH   = 4,
  parameter int QUEUE_DEPTH   = 8,
  parameter int WR_HIGH_WM    = 6,
  parameter int WR_LOW_WM     = 2,
  parameter int STARVE_LIMIT  = 16,
  parameter int NUM_FSM       = 4,
  parameter int MEM_ADDRWIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdReqValid,
  output logic                          rdReqReady,
  input  logic [AXI_ADDRWIDTH-1:0]      rdReqAddr,
  input  logic [AXI_IDWIDTH-1:0]        rdReqId,
  input  logic                          wrReqValid,
  output logic                          wrReqReady,
  input  logic [AXI_ADDRWIDTH-1:0]      wrReqAddr,
  input  logic [AXI_IDWIDTH-1:0]        wrReqId,
  input  logic [NUM_FSM-1:0]            fsmReady,
  output logic                          issueValid,
  output logic                          issueIsWrite,
  output logic [AXI_ADDRWIDTH-1:0]      issueAddr,
  output logic [AXI_IDWIDTH-1:0]        issueId,
  output logic [NUM_FSM-1:0]            issueTarget,
  output logic                          issueFire,
  output logic                          writeDrainMode,
  output logic [$clog2(QUEUE_DEPTH):0]  rdCount,
  output logic [$clog2(QUEUE_DEPTH):0]  wrCount
);
  localparam int CW          = $clog2(QUEUE_DEPTH) + 1;
  localparam int NUM_FSM_BIT = $clog2(NUM_FSM);
  localparam int SW          = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] HIGH_WM    = CW'(WR_HIGH_WM);
  localparam logic [CW-1:0] LOW_WM     = CW'(WR_LOW_WM);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [0:0] MODE_READ  = 1'b0;
  localparam logic [0:0] MODE_DRAIN = 1'b1;

  typedef struct packed {
    logic [AXI_IDWIDTH-1:0]   id;
    logic [AXI_ADDRWIDTH-1:0] addr;
  } req_t;

  req_t                   rd_in, wr_in, rd_head, wr_head, head;
  logic                   rd_full, wr_full, rd_push, wr_push, rd_pop, wr_pop;
  logic [NUM_FSM_BIT-1:0] tgt_idx;
  logic [0:0]             mode_q, mode_d;
  logic [SW-1:0]          starve_q, starve_d;

  assign rd_in.id   = rdReqId;
  assign rd_in.addr = rdReqAddr;
  assign wr_in.id   = wrReqId;
  assign wr_in.addr = wrReqAddr;

  assign rdReqReady = !rd_full;
  assign wrReqReady = !wr_full;
  assign rd_push    = rdReqValid && rdReqReady;
  assign wr_push    = wrReqValid && wrReqReady;

  rw_req_fifo #(.W($bits(req_t)), .DEPTH(QUEUE_DEPTH)) u_rd_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (rd_push),
    .data_i (rd_in),
    .pop_i  (rd_pop),
    .head_o (rd_head),
    .count_o(rdCount),
    .full_o (rd_full)
  );

  rw_req_fifo #(.W($bits(req_t)), .DEPTH(QUEUE_DEPTH)) u_wr_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (wr_push),
    .data_i (wr_in),
    .pop_i  (wr_pop),
    .head_o (wr_head),
    .count_o(wrCount),
    .full_o (wr_full)
  );

  // Only the mode-selected head is ever presented, even if its target FSM is stalled.
  always_comb begin
    head         = (mode_q == MODE_DRAIN) ? wr_head : rd_head;
    issueValid   = (mode_q == MODE_DRAIN) ? (wrCount != '0) : (rdCount != '0);
    issueIsWrite = issueValid && (mode_q == MODE_DRAIN);
    issueAddr    = issueValid ? head.addr : '0;
    issueId      = issueValid ? head.id : '0;
    tgt_idx      = issueAddr[MEM_ADDRWIDTH-1 -: NUM_FSM_BIT];
    issueTarget  = issueValid ? (NUM_FSM'(1) << tgt_idx) : '0;
    issueFire    = issueValid && fsmReady[tgt_idx];
  end

  assign rd_pop = issueFire && !issueIsWrite;
  assign wr_pop = issueFire && issueIsWrite;

  always_comb begin
    mode_d = mode_q;
    if (mode_q == MODE_READ) begin
      if (wrCount >= HIGH_WM || (rdCount == '0 && wrCount != '0) || starve_q >= STARVE_MAX)
        mode_d = MODE_DRAIN;
    end else if (wrCount == '0 || (wrCount <= LOW_WM && rdCount != '0)) begin
      mode_d = MODE_READ;
    end

    starve_d = starve_q;
    if (wr_pop || wrCount == '0 || (mode_q == MODE_READ && mode_d == MODE_DRAIN))
      starve_d = '0;
    else if (rd_pop && starve_q < STARVE_MAX)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_READ;
      starve_q <= '0;
    end else begin
      mode_q   <= mode_d;
      starve_q <= starve_d;
    end
  end

  assign writeDrainMode = (mode_q == MODE_DRAIN);
endmodule

// File: doc/rw_request_scheduler.md
# rw_request_scheduler

Front-end scheduler between the AXI slave request capture and the address translation stage. It buffers incoming read and write requests in two FIFOs and applies a read-priority / write-drain watermark policy with a write-starvation limit. It presents one request per cycle to the per-(channel, rank) FSM array and completes the handshake only when the target FSM reports ready.

## Interface
- AXI_ADDRWIDTH, 32, request address width.
- AXI_IDWIDTH, 4, request ID width carried with each entry.
- QUEUE_DEPTH, 8, entries per queue (power of two, ≥4).
- WR_HIGH_WM, 6, write count that forces write-drain mode.
- WR_LOW_WM, 2, write count at or below which drain may end (< WR_HIGH_WM).
- STARVE_LIMIT, 16, consecutive read issues tolerated while writes wait.
- NUM_FSM, 4, number of target FSMs. NUM_FSM_BIT = log2(NUM_FSM).
- MEM_ADDRWIDTH, 32, target index = addr[MEM_ADDRWIDTH-1 -: NUM_FSM_BIT].

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdReqValid / rdReqReady  in / out  1  read enqueue handshake; rdReqReady = !rdFull.
- rdReqAddr  in  AXI_ADDRWIDTH  read address.  rdReqId  in  AXI_IDWIDTH  read ID.
- wrReqValid / wrReqReady  in / out  1  write enqueue handshake; wrReqReady = !wrFull.
- wrReqAddr  in  AXI_ADDRWIDTH.  wrReqId  in  AXI_IDWIDTH.
- fsmReady  in  NUM_FSM  per-FSM accept-ready.
- issueValid  out  1  a request is presented.
- issueIsWrite  out  1  1 = presented request is a write.
- issueAddr  out  AXI_ADDRWIDTH.  issueId  out  AXI_IDWIDTH.
- issueTarget  out  NUM_FSM  one-hot target FSM; zero when !issueValid.
- issueFire  out  1  issueValid && fsmReady[target]; head is popped this edge.
- writeDrainMode  out  1  current mode register.
- rdCount / wrCount  out  log2(QUEUE_DEPTH)+1  occupancy.

## Operation
- Queues: synchronous FIFOs, push on valid&&ready, pop on issueFire of the matching type. Push on a full queue is impossible (ready low); no pass-through from input to issue.
- Modes: READ (reset) and DRAIN.
- READ: issueValid = rdCount>0, presenting the read head. DRAIN: issueValid = wrCount>0, presenting the write head. The non-selected queue is never presented, even when the selected queue's target is not ready. This is strict head-of-line order with no reordering.
- READ → DRAIN when any of the following holds on registered values:
  - wrCount ≥ WR_HIGH_WM;
  - rdCount==0 && wrCount>0;
  - starveCnt ≥ STARVE_LIMIT.
- DRAIN → READ when either holds:
  - wrCount==0;
  - wrCount ≤ WR_LOW_WM && rdCount>0.
- starveCnt: increments on each read issueFire while wrCount>0. Clears on any write issueFire, on entering DRAIN, or when wrCount==0. Saturates at STARVE_LIMIT.
- Target index = issueAddr[MEM_ADDRWIDTH-1 -: NUM_FSM_BIT]; issueTarget = one-hot of it when issueValid.

## Timing
- Reset values:
  - mode READ, writeDrainMode 0;
  - counts 0, pointers 0, starveCnt 0;
  - issueValid/issueFire/issueIsWrite 0, issueTarget 0, issueAddr/issueId 0;
  - rdReqReady/wrReqReady 1 once rst deasserts.
- Enqueue-to-issue latency: a request pushed at edge N can be presented (issueValid) in cycle N+1, and fire in that cycle if the FSM is ready.
- Mode next-state uses registered counts and starveCnt and takes effect one edge later. A mode change never drops or duplicates the head; the head that fired was already popped.
- Issue outputs are combinational from registered head, mode and fsmReady. Throughput is one issue per cycle.
- Simultaneous push and pop on the same queue: count unchanged, and a full queue stays non-full for the next cycle only if a pop occurred.
- Wrap-around: pointers wrap modulo QUEUE_DEPTH. Occupancy is exact with the extra count bit.
- rst asserted mid-operation: all queued requests are discarded and all outputs return to reset values immediately (asynchronous).

## Test plan
- Reset, then push read 0x4000_0000 (id 3) with fsmReady=4'b1111 → issue in next cycle with issueTarget=4'b0010, issueIsWrite=0, issueId=3; rdCount returns to 0.
- Push 6 writes with no reads, fsmReady=0 → writeDrainMode=1 after 2 cycles. Release fsmReady: all 6 writes issue back-to-back in order, then mode returns to READ.
- Preload 8 reads and 1 write, fsmReady all 1 → reads issue until starveCnt=16 requires reads to be re-supplied. Verify the write issues within one cycle of the limit, then starveCnt=0.
- Fill the read queue to 8 → rdReqReady=0. Push and pop in the same cycle at full → count stays 8→7→8 correctly across pointer wrap.
- Read head targets FSM 2 with fsmReady[2]=0 and the write queue holding 1 entry, rdCount>0 → no issue; the write is not bypassed until the mode switches.
- Assert rst with 5 reads and 3 writes queued → counts 0, issueValid 0 immediately. After release, a new read issues normally.
